// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM state codes and RV32I
// load/store width codes, plus small legality helpers used by the datapath.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Width is encoded in funct3[1:0] for both directions.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: moves the addressed lane(s) of a memory word down to
// bit 0 and sign- or zero-extends according to the load width code.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        case (funct3)
            F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata = word;
            F3_LBU:  rdata = {24'h0, shifted[7:0]};
            F3_LHU:  rdata = {16'h0, shifted[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, performs
// it in the ACCESS cycle and holds the response until it is taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]        state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_funct3;

    // Contents start at zero and deliberately survive reset.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] word_idx;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       load_data;
    logic              do_write;

    assign req_ready = (state == ST_IDLE);
    assign idx       = r_addr[IDX_W+1:2];
    assign word_idx  = {2'b00, r_addr[ADDR_W-1:2]};

    always_comb begin
        err = !funct3_legal(r_we, r_funct3) ||
              misaligned(r_funct3, r_addr[1:0]) ||
              (word_idx >= ADDR_W'(DEPTH_WORDS));
        case (r_funct3[1:0])
            2'b00: begin
                be = 4'b0001 << r_addr[1:0];
                wd = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                be = r_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
                wd = r_wdata;
            end
            default: begin
                be = 4'b0000;
                wd = '0;
            end
        endcase
        do_write = (state == ST_ACCESS) && r_we && !err;
    end

    dmem_load_align u_load_align (
        .word   (mem[idx]),
        .lane   (r_addr[1:0]),
        .funct3 (r_funct3),
        .rdata  (load_data)
    );

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (r_we || err) ? '0 : load_data;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed load/store results,
// error cases, response back-pressure and mid-transaction reset.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one transaction with rsp_ready high; lat counts negedges from the
    // accept edge until rsp_valid is seen (-1 on timeout).
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'b111;
        lat = 0; rd = '0; er = 1'b0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid || n >= 10) lat = -1;
        rd = rsp_rdata; er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
        #3;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", rsp_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'b010, 32'h0, 32'd1337, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d exp 2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_rsp: got err=%b rd=%h exp err=0 rd=0", er, rd); end
        xact(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d exp 2", lat); end
        checks++; if (rd !== 32'd1337 || er !== 1'b0) begin errors++; $display("FAIL lw0: got rd=%h err=%b exp rd=%h err=0", rd, er, 32'd1337); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'b010, 32'h4, 32'h11223344, rd, er, lat);
        xact(1'b1, 3'b000, 32'h6, 32'h123456AA, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb_err: got %b exp 0", er); end
        xact(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL lw4_after_sb: got %h exp 11aa3344", rd); end
        xact(1'b0, 3'b000, 32'h6, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb6: got %h exp ffffffaa", rd); end
        xact(1'b0, 3'b100, 32'h6, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu6: got %h exp 000000aa", rd); end
        xact(1'b0, 3'b000, 32'h5, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000033) begin errors++; $display("FAIL lb5: got %h exp 00000033", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 3'b001, 32'hA, 32'hCDEF8001, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sh_err: got %b exp 0", er); end
        xact(1'b0, 3'b001, 32'hA, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_a: got %h exp ffff8001", rd); end
        xact(1'b0, 3'b101, 32'hA, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_a: got %h exp 00008001", rd); end
        xact(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h80010000) begin errors++; $display("FAIL lw8_after_sh: got %h exp 80010000", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 3'b010, 32'h2, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misaligned: got err=%b rd=%h exp err=1 rd=0", er, rd); end
        xact(1'b0, 3'b001, 32'h5, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh_misaligned: got err=%b rd=%h exp err=1 rd=0", er, rd); end
        xact(1'b0, 3'b011, 32'h0, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL load_f3_011: got err=%b exp 1", er); end
        xact(1'b1, 3'b010, 32'h400, 32'hBADC0DE5, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sw_oor: got err=%b rd=%h exp err=1 rd=0", er, rd); end
        xact(1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL store_f3_100: got err=%b exp 1", er); end
        xact(1'b1, 3'b001, 32'h1, 32'hFFFFFFFF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got err=%b exp 1", er); end
        xact(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'd1337 || er !== 1'b0) begin errors++; $display("FAIL mem_after_err_stores: got rd=%h err=%b exp rd=%h err=0", rd, er, 32'd1337); end
        xact(1'b0, 3'b010, 32'h3FC, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL lw_last_word: got err=%b rd=%h exp err=0 rd=0", er, rd); end
    endtask

    task automatic test_stall;
        logic [31:0] rd; logic er; int lat;
        int n;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = '0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL stall_latency: got %0d exp 2", n); end
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
            req_addr = 32'h4; req_wdata = 32'hDEADBEEF;
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b exp 1", c, rsp_valid); end
            checks++; if (rsp_rdata !== 32'h11AA3344) begin errors++; $display("FAIL stall_rdata[%0d]: got %h exp 11aa3344", c, rsp_rdata); end
            checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL stall_err[%0d]: got %b exp 0", c, rsp_err); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b exp 0", c, req_ready); end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready); end
        xact(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL ignored_req_no_write: got %h exp 11aa3344", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        // Reset during ACCESS: the store never reaches memory.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h55;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_in_access: got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h80010000) begin errors++; $display("FAIL rst_access_mem: got %h exp 80010000", rd); end
        // Reset after the ACCESS edge: the store has landed, response is dropped.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h55;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_in_resp: got valid=%b ready=%b rd=%h exp 0/1/0", rsp_valid, req_ready, rsp_rdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000055) begin errors++; $display("FAIL rst_resp_mem: got %h exp 00000055", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int lat;
        time t0, t1;
        xact(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
        t0 = $time;
        xact(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat);
        t1 = $time;
        checks++; if (t1 - t0 !== 30) begin errors++; $display("FAIL b2b_spacing: got %0t exp 30", t1 - t0); end
        checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL b2b_data: got %h exp 11aa3344", rd); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_errors;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit memory words.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1 bit, meaning a request is present.
REQ-006 SHALL have port req_ready, output, 1 bit, meaning the block can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, ADDR_W bits, the byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits, the store data, LSB-aligned.
REQ-010 SHALL have port req_funct3, input, 3 bits, the RV32I width code: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use 000/001/010.
REQ-011 SHALL have port rsp_valid, output, 1 bit, meaning a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit, meaning the requester accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits, the extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit, meaning a misaligned, out-of-range or illegal-funct3 access.

Function
REQ-015 SHALL implement FSM IDLE, ACCESS and RESP.
- IDLE -> ACCESS on req_valid && req_ready.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE on rsp_ready.
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 SHALL capture we, addr, wdata and funct3 in request registers on the accepting edge; later changes to the inputs SHALL NOT affect the transaction.
REQ-018 SHALL assert rsp_valid exactly two cycles after the accept edge and hold it, with rdata and err, stable until the rsp_ready handshake.
REQ-019 SHALL accept a new request at the earliest one cycle after the response handshake, so throughput is at most one transaction per 3 cycles.
REQ-020 SHALL index memory by word as addr[ADDR_W-1:2] and select lanes by addr[1:0].
REQ-021 SHALL flag err when a halfword access has addr[0]=1, a word access has addr[1:0]!=0, or the word index is >= DEPTH_WORDS.
REQ-022 SHALL flag err when funct3 is illegal for the direction; this includes a store with funct3 100 or 101.
REQ-023 SHALL leave memory unmodified on any errored store.
REQ-024 SHALL on a store write only the addressed byte lanes:
- SB writes wdata[7:0] to lane addr[1:0].
- SH writes wdata[15:0] to lanes 2*addr[1] and 2*addr[1]+1.
- SW writes all four lanes.
REQ-025 SHALL on a load shift the selected lane(s) to bit 0 and extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through unchanged.
REQ-026 SHALL perform the memory write in the ACCESS cycle, so that a load issued after a store's response observes the stored value.
REQ-027 SHALL ignore req_valid while not in IDLE; no queuing and no error for such requests.
REQ-028 SHALL initialise memory contents to zero at time zero.

Reset
REQ-029 SHALL on rst_n low, immediately and regardless of clk, force:
- state to IDLE
- rsp_valid=0, rsp_err=0, rsp_rdata=0
- all request registers to 0
REQ-030 SHALL have req_ready=1 during and after reset.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL abort any in-flight transaction on reset mid-operation: no response is produced. A store reset in IDLE or before its ACCESS edge SHALL leave memory unmodified.

Structure
REQ-033 SHALL take the FSM state encoding and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) from shared package dmem_pkg.
REQ-034 SHALL instantiate one combinational sub-module, dmem_load_align, that maps (word, addr[1:0], funct3) to the extended rdata.

Verification
REQ-035 Bench SHALL cover: SW 1337 @0x0, then LW @0x0 -> rsp_rdata=1337, rsp_err=0, rsp_valid two cycles after each accept.
REQ-036 Bench SHALL cover: SW 0x11223344 @0x4, SB 0xAA @0x6, then LW @0x4 -> 0x11AA3344; LB @0x6 -> 0xFFFFFFAA; LBU @0x6 -> 0x000000AA.
REQ-037 Bench SHALL cover: SH 0x8001 @0xA, then LH @0xA -> 0xFFFF8001; LHU @0xA -> 0x00008001.
REQ-038 Bench SHALL cover: LW @0x2 -> rsp_err=1, rdata=0; SW @0x400 with DEPTH_WORDS=256 -> err=1, memory unchanged.
REQ-039 Bench SHALL cover: rsp_ready held low 5 cycles -> rsp_valid, rdata and err stable, req_ready=0 throughout, and a concurrent req_valid is ignored.
REQ-040 Bench SHALL cover: rst_n asserted in ACCESS of SW 0x55 @0x8 -> rsp_valid=0 immediately, req_ready=1; a subsequent LW @0x8 returns 0x55 only if the ACCESS edge preceded reset, else the prior value.
